gan_pixel_streamer: RTL and testbench

GAN_PIXEL_STREAMER -- requirements
Module: gan_pixel_streamer

---
 rtl/gan_pkg.sv | 21 ++
 rtl/pixel_threshold.sv | 22 ++
 rtl/gan_pixel_streamer.sv | 133 +++++++++++++
 tb/tb_gan_pixel_streamer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gan_pkg.sv
// Shared definitions for the GAN pixel streamer: pixel width default,
// Q8.24 fixed-point constants, frame geometry and the FSM state type.
package gan_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int PIX_COUNT     = 9;

    // Index of the final pixel in a frame (3x3, row-major).
    localparam logic [3:0] LAST_INDEX = 4'(PIX_COUNT - 1);

    // Q8.24 signed fixed-point constants.
    localparam logic signed [WIDTH_DEFAULT-1:0] Q_ZERO = 32'sh0000_0000;
    localparam logic signed [WIDTH_DEFAULT-1:0] Q_HALF = 32'sh0080_0000;
    localparam logic signed [WIDTH_DEFAULT-1:0] Q_ONE  = 32'sh0100_0000;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/pixel_threshold.sv
// Binarizes one Q8.24 pixel: values at or above one half become one,
// everything else becomes zero. Only compiled when PIXEL_THRESHOLD_EN
// is defined, since only that build instantiates it.
`ifdef PIXEL_THRESHOLD_EN
module pixel_threshold
    import gan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic signed [WIDTH-1:0] pixel,
    output logic signed [WIDTH-1:0] binarized
);

    localparam logic signed [WIDTH-1:0] HALF = WIDTH'(Q_HALF);
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(Q_ONE);
    localparam logic signed [WIDTH-1:0] ZERO = WIDTH'(Q_ZERO);

    // Signed compare so negative pixels always map to zero.
    assign binarized = (pixel >= HALF) ? ONE : ZERO;

endmodule
`endif

// File: rtl/gan_pixel_streamer.sv
// Captures a 3x3 generator frame on a ready/valid request and streams the
// nine pixels row-major over a registered valid/ready master port.
// Build option: define PIXEL_THRESHOLD_EN to binarize pixels at capture;
// the handshake and timing are identical in both builds.
module gan_pixel_streamer
    import gan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] pixel_1x1,
    input  logic signed [WIDTH-1:0] pixel_1x2,
    input  logic signed [WIDTH-1:0] pixel_1x3,
    input  logic signed [WIDTH-1:0] pixel_2x1,
    input  logic signed [WIDTH-1:0] pixel_2x2,
    input  logic signed [WIDTH-1:0] pixel_2x3,
    input  logic signed [WIDTH-1:0] pixel_3x1,
    input  logic signed [WIDTH-1:0] pixel_3x2,
    input  logic signed [WIDTH-1:0] pixel_3x3,
    input  logic                    cap_valid,
    output logic                    cap_ready,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [3:0]              m_index,
    output logic                    m_first,
    output logic                    m_last,
    output logic [15:0]             frame_count
);

    logic signed [WIDTH-1:0] raw_pix [PIX_COUNT];
    logic signed [WIDTH-1:0] cap_pix [PIX_COUNT];
    logic signed [WIDTH-1:0] pix_buf [PIX_COUNT];

    state_t     state, state_next;
    logic       capture;
    logic       xfer;
    logic       last_xfer;
    logic [3:0] next_index;

    assign raw_pix = '{pixel_1x1, pixel_1x2, pixel_1x3,
                       pixel_2x1, pixel_2x2, pixel_2x3,
                       pixel_3x1, pixel_3x2, pixel_3x3};

`ifdef PIXEL_THRESHOLD_EN
    for (genvar g = 0; g < PIX_COUNT; g++) begin : g_thr
        pixel_threshold #(.WIDTH(WIDTH)) u_thr (
            .pixel     (raw_pix[g]),
            .binarized (cap_pix[g])
        );
    end
`else
    assign cap_pix = raw_pix;
`endif

    assign next_index = m_index + 4'd1;

    // Next-state decode: capture in IDLE, return to IDLE after the last beat.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        capture    = 1'b0;
        xfer       = 1'b0;
        last_xfer  = 1'b0;
        case (state)
            IDLE: begin
                if (cap_valid && cap_ready) begin
                    capture    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                xfer      = m_valid && m_ready;
                last_xfer = xfer && (m_index == LAST_INDEX);
                if (last_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame buffer and registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the buffer is cleared in reset so no stale frame survives; this forces it into flops, not RAM.
            for (int i = 0; i < PIX_COUNT; i++) begin
                pix_buf[i] <= '0;
            end
            cap_ready   <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_index     <= '0;
            m_first     <= 1'b0;
            m_last      <= 1'b0;
            frame_count <= '0;
        end else if (capture) begin
            pix_buf   <= cap_pix;
            cap_ready <= 1'b0;
            m_valid   <= 1'b1;
            m_data    <= cap_pix[0];
            m_index   <= '0;
            m_first   <= 1'b1;
            m_last    <= 1'b0;
        end else if (state == IDLE) begin
            // First edge after reset release (or idle hold) opens the capture port.
            cap_ready <= 1'b1;
        end else if (last_xfer) begin
            m_valid     <= 1'b0;
            cap_ready   <= 1'b1;
            m_first     <= 1'b0;
            m_last      <= 1'b0;
            frame_count <= frame_count + 16'd1;
        end else if (xfer) begin
            m_index <= next_index;
            m_data  <= pix_buf[next_index];
            m_first <= 1'b0;
            m_last  <= (next_index == LAST_INDEX);
        end
    end

endmodule

// File: tb/tb_gan_pixel_streamer.sv
// Directed self-checking bench for gan_pixel_streamer. The expected pixel
// values follow the build: raw pass-through by default, binarized when
// PIXEL_THRESHOLD_EN is defined.
module tb_gan_pixel_streamer;

    logic               clk;
    logic               rst;
    logic signed [31:0] pix [9];
    logic               cap_valid;
    logic               cap_ready;
    logic signed [31:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic [3:0]         m_index;
    logic               m_first;
    logic               m_last;
    logic [15:0]        frame_count;

    logic [31:0]        exp_pix [9];
    int                 n_checks = 0;
    int                 n_errors = 0;

    gan_pixel_streamer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pixel_1x1   (pix[0]),
        .pixel_1x2   (pix[1]),
        .pixel_1x3   (pix[2]),
        .pixel_2x1   (pix[3]),
        .pixel_2x2   (pix[4]),
        .pixel_2x3   (pix[5]),
        .pixel_3x1   (pix[6]),
        .pixel_3x2   (pix[7]),
        .pixel_3x3   (pix[8]),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_index     (m_index),
        .m_first     (m_first),
        .m_last      (m_last),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference value the streamer should emit for a captured pixel.
    function automatic logic [31:0] model_pix(input logic [31:0] v);
`ifdef PIXEL_THRESHOLD_EN
        return ($signed(v) >= 32'sh0080_0000) ? 32'h0100_0000 : 32'h0000_0000;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input int i);
        check($sformatf("beat%0d valid", i), 32'(m_valid), 32'd1);
        check($sformatf("beat%0d data", i),  m_data, exp_pix[i]);
        check($sformatf("beat%0d index", i), 32'(m_index), 32'(i));
        check($sformatf("beat%0d first", i), 32'(m_first), 32'(i == 0));
        check($sformatf("beat%0d last", i),  32'(m_last), 32'(i == 8));
    endtask

    // Called on a falling edge; returns on the falling edge where beat 0 is visible.
    task automatic capture_frame(input logic [31:0] v [9]);
        for (int i = 0; i < 9; i++) begin
            pix[i]     = v[i];
            exp_pix[i] = model_pix(v[i]);
        end
        cap_valid = 1'b1;
        @(negedge clk);
        cap_valid = 1'b0;
        check("cap_ready low after capture", 32'(cap_ready), 32'd0);
    endtask

    // Streams beats lo..hi with m_ready held high, one beat per clock.
    task automatic stream_beats(input int lo, input int hi);
        m_ready = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            expect_beat(i);
            @(negedge clk);
        end
    endtask

    logic [31:0] frame_a [9];
    logic [31:0] frame_b [9];
    logic [31:0] frame_t [9];

    initial begin
        for (int i = 0; i < 9; i++) begin
            frame_a[i] = 32'(i + 1) << 24;
            frame_b[i] = 32'(i + 17) << 24;
            pix[i]     = '0;
        end
        frame_t = '{32'h007F_FFFF, 32'h0080_0000, 32'hFF00_0000,
                    32'h0100_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                    32'h0080_0001, 32'h0000_0000, 32'hFFFF_FFFF};

        // Reset held low: everything zero, capture port closed.
        rst = 1'b0; cap_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst cap_ready", 32'(cap_ready), 32'd0);
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst m_data", m_data, 32'd0);
        check("rst m_index", 32'(m_index), 32'd0);
        check("rst m_first", 32'(m_first), 32'd0);
        check("rst m_last", 32'(m_last), 32'd0);
        check("rst frame_count", 32'(frame_count), 32'd0);
        rst = 1'b1;
        check("cap_ready before first edge", 32'(cap_ready), 32'd0);
        @(negedge clk);
        check("cap_ready after first edge", 32'(cap_ready), 32'd1);
        check("idle m_valid", 32'(m_valid), 32'd0);

        // Frame 1: continuous m_ready, nine back-to-back beats.
        capture_frame(frame_a);
        stream_beats(0, 8);
        check("f1 m_valid cleared", 32'(m_valid), 32'd0);
        check("f1 cap_ready", 32'(cap_ready), 32'd1);
        check("f1 frame_count", 32'(frame_count), 32'd1);

        // Frame 2: backpressure for three edges at index 4.
        capture_frame(frame_a);
        stream_beats(0, 3);
        m_ready = 1'b0;
        expect_beat(4);
        repeat (3) begin
            @(negedge clk);
            expect_beat(4);
        end
        m_ready = 1'b1;
        @(negedge clk);
        stream_beats(5, 8);
        check("f2 frame_count", 32'(frame_count), 32'd2);

        // Frame 3: new pixels and cap_valid mid-frame must not disturb it;
        // cap_valid stays high through the last beat and captures one edge later.
        capture_frame(frame_a);
        stream_beats(0, 1);
        for (int i = 0; i < 9; i++) pix[i] = frame_b[i];
        cap_valid = 1'b1;
        stream_beats(2, 8);
        check("f3 m_valid after last", 32'(m_valid), 32'd0);
        check("f3 cap_ready after last", 32'(cap_ready), 32'd1);
        check("f3 frame_count", 32'(frame_count), 32'd3);
        for (int i = 0; i < 9; i++) exp_pix[i] = model_pix(frame_b[i]);
        @(negedge clk);
        cap_valid = 1'b0;
        check("f4 cap_ready low", 32'(cap_ready), 32'd0);
        stream_beats(0, 8);
        check("f4 frame_count", 32'(frame_count), 32'd4);

        // Frame 5: reset at index 5 aborts the frame.
        capture_frame(frame_a);
        stream_beats(0, 4);
        expect_beat(5);
        rst = 1'b0;
        #1;
        check("abort m_valid", 32'(m_valid), 32'd0);
        check("abort m_data", m_data, 32'd0);
        check("abort m_index", 32'(m_index), 32'd0);
        check("abort m_last", 32'(m_last), 32'd0);
        check("abort cap_ready", 32'(cap_ready), 32'd0);
        check("abort frame_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-abort cap_ready", 32'(cap_ready), 32'd1);
        check("post-abort m_valid", 32'(m_valid), 32'd0);
        check("post-abort frame_count", 32'(frame_count), 32'd0);

        // Frame 6: threshold boundary values, streamed from index 0.
        capture_frame(frame_t);
        stream_beats(0, 8);
        check("f6 frame_count", 32'(frame_count), 32'd1);
        check("f6 idle m_valid", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
